// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm sequencer and the downstream RGB LED
// controller: the 4-bit alarm state codes and the timer / snooze widths.
// -----------------------------------------------------------------------------
package alarm_pkg;

  localparam int TMR_W = 12;
  localparam int SNZ_W = 3;

  // Codes are consumed directly by the RGB controller; do not renumber.
  typedef enum logic [3:0] {
    IDLE   = 4'b1000,
    ACTIVE = 4'b1001,
    WAKE   = 4'b1010,
    SNOOZE = 4'b1011
  } alarm_state_e;

endpackage

// File: rtl/alarm_sec_timer.sv
// -----------------------------------------------------------------------------
// alarm_sec_timer
// Counts sec_tick pulses since the last clear and pulses expire on the
// limit-th tick.
// Ports:
//   GCLK      in   system clock
//   RST       in   asynchronous reset, active-high
//   clear     in   restart the count (a tick in the same cycle is dropped)
//   sec_tick  in   one-cycle pulse per second
//   limit     in   number of ticks to expiry (1..4095)
//   expire    out  combinational pulse: sec_tick with count == limit-1
// -----------------------------------------------------------------------------
module alarm_sec_timer
  import alarm_pkg::*;
(
  input  logic             GCLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             sec_tick,
  input  logic [TMR_W-1:0] limit,
  output logic             expire
);

  logic [TMR_W-1:0] cnt;

  assign expire = sec_tick && (cnt == (limit - TMR_W'(1)));

  // Saturates at all-ones so a state that ignores expiry (WAKE without
  // auto-off) can sit indefinitely without the count wrapping.
  always_ff @(posedge GCLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (sec_tick && (cnt != '1)) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
// Alarm-sequencing FSM driving the RGB LED controller's alarm-state input:
// IDLE -> ACTIVE (fade) -> WAKE (blink + buzzer), with snooze and dismiss.
// Optional feature macro: ALARM_AUTO_OFF_EN -- when defined, WAKE returns to
// IDLE on its WAKE_TIMEOUT_S-th sec_tick.
// Ports:
//   GCLK            in   system clock
//   RST             in   asynchronous reset, active-high
//   sec_tick        in   one-GCLK pulse per second
//   cur_hour/min    in   current time (binary)
//   alarm_hour/min  in   programmed alarm time (binary)
//   alarm_enable    in   level; 0 forces IDLE
//   snooze_pulse    in   one-cycle snooze press
//   dismiss_pulse   in   one-cycle dismiss press
//   alarm_state_out out  registered state code (see alarm_pkg)
//   buzzer_en       out  registered, high only in WAKE
//   snooze_count    out  registered, snoozes used in this alarm event
// -----------------------------------------------------------------------------
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int FADE_SECONDS   = 30,
  parameter int SNOOZE_SECONDS = 300,
  parameter int WAKE_TIMEOUT_S = 600,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic             GCLK,
  input  logic             RST,
  input  logic             sec_tick,
  input  logic [4:0]       cur_hour,
  input  logic [5:0]       cur_min,
  input  logic [4:0]       alarm_hour,
  input  logic [5:0]       alarm_min,
  input  logic             alarm_enable,
  input  logic             snooze_pulse,
  input  logic             dismiss_pulse,
  output logic [3:0]       alarm_state_out,
  output logic             buzzer_en,
  output logic [SNZ_W-1:0] snooze_count
);

  alarm_state_e     state_q, state_nxt;
  logic [SNZ_W-1:0] snz_nxt;
  logic             armed_q, armed_nxt;
  logic             match;
  logic             snooze_ok;
  logic             tmr_clear;
  logic             tmr_expire;
  logic [TMR_W-1:0] tmr_limit;

  assign match     = (cur_hour == alarm_hour) && (cur_min == alarm_min);
  assign snooze_ok = snooze_pulse && (snooze_count < SNZ_W'(MAX_SNOOZES));

  // Single timer shared by all timed states; its limit follows the state.
  always_comb begin
    tmr_limit = TMR_W'(FADE_SECONDS);
    case (state_q)
      SNOOZE:  tmr_limit = TMR_W'(SNOOZE_SECONDS);
      WAKE:    tmr_limit = TMR_W'(WAKE_TIMEOUT_S);
      default: tmr_limit = TMR_W'(FADE_SECONDS);
    endcase
  end

  // Every state entry restarts the timer, which also drops a coincident tick.
  assign tmr_clear = (state_nxt != state_q);

  alarm_sec_timer u_timer (
    .GCLK     (GCLK),
    .RST      (RST),
    .clear    (tmr_clear),
    .sec_tick (sec_tick),
    .limit    (tmr_limit),
    .expire   (tmr_expire)
  );

  // Button presses are checked before expiry so a press always wins.
  // A snooze from ACTIVE draws on the same per-event budget as one from WAKE.
  always_comb begin
    state_nxt = state_q;
    snz_nxt   = snooze_count;
    if (!alarm_enable) begin
      state_nxt = IDLE;
      snz_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match && armed_q) begin
            state_nxt = ACTIVE;
            snz_nxt   = '0;
          end
        end
        ACTIVE: begin
          if (dismiss_pulse) begin
            state_nxt = IDLE;
          end else if (snooze_ok) begin
            state_nxt = SNOOZE;
            snz_nxt   = snooze_count + SNZ_W'(1);
          end else if (tmr_expire) begin
            state_nxt = WAKE;
          end
        end
        WAKE: begin
          if (dismiss_pulse) begin
            state_nxt = IDLE;
          end else if (snooze_ok) begin
            state_nxt = SNOOZE;
            snz_nxt   = snooze_count + SNZ_W'(1);
          end
`ifdef ALARM_AUTO_OFF_EN
          else if (tmr_expire) begin
            state_nxt = IDLE;
          end
`endif
        end
        SNOOZE: begin
          if (dismiss_pulse) begin
            state_nxt = IDLE;
          end else if (tmr_expire) begin
            state_nxt = WAKE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Leaving for IDLE inside the matching minute disarms until the minute
  // changes, giving one alarm event per matching minute.
  always_comb begin
    armed_nxt = armed_q;
    if ((state_nxt == IDLE) && (state_q != IDLE) && match) begin
      armed_nxt = 1'b0;
    end else if (!match) begin
      armed_nxt = 1'b1;
    end
  end

  always_ff @(posedge GCLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      buzzer_en    <= 1'b0;
      snooze_count <= '0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_nxt;
      buzzer_en    <= (state_nxt == WAKE);
      snooze_count <= snz_nxt;
      armed_q      <= armed_nxt;
    end
  end

  assign alarm_state_out = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
// Directed bench for alarm_sequencer with the default timing parameters
// (fade 30 s, snooze 300 s, 3 snoozes) and WAKE_TIMEOUT_S=5. Optional feature
// macro: ALARM_AUTO_OFF_EN selects the expected WAKE timeout behaviour.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

  localparam logic [3:0] S_IDLE   = 4'b1000;
  localparam logic [3:0] S_ACTIVE = 4'b1001;
  localparam logic [3:0] S_WAKE   = 4'b1010;
  localparam logic [3:0] S_SNOOZE = 4'b1011;

  logic       GCLK = 1'b0;
  logic       RST = 1'b1;
  logic       sec_tick = 1'b0;
  logic [4:0] cur_hour = 5'd7;
  logic [5:0] cur_min = 6'd29;
  logic [4:0] alarm_hour = 5'd7;
  logic [5:0] alarm_min = 6'd30;
  logic       alarm_enable = 1'b1;
  logic       snooze_pulse = 1'b0;
  logic       dismiss_pulse = 1'b0;
  logic [3:0] alarm_state_out;
  logic       buzzer_en;
  logic [2:0] snooze_count;

  int n_checks = 0;
  int n_pass   = 0;

  alarm_sequencer #(
    .FADE_SECONDS   (30),
    .SNOOZE_SECONDS (300),
    .WAKE_TIMEOUT_S (5),
    .MAX_SNOOZES    (3)
  ) dut (
    .GCLK            (GCLK),
    .RST             (RST),
    .sec_tick        (sec_tick),
    .cur_hour        (cur_hour),
    .cur_min         (cur_min),
    .alarm_hour      (alarm_hour),
    .alarm_min       (alarm_min),
    .alarm_enable    (alarm_enable),
    .snooze_pulse    (snooze_pulse),
    .dismiss_pulse   (dismiss_pulse),
    .alarm_state_out (alarm_state_out),
    .buzzer_en       (buzzer_en),
    .snooze_count    (snooze_count)
  );

  always #5 GCLK = ~GCLK;

  typedef struct {
    logic       en;
    logic       sn;
    logic       dis;
    logic [5:0] cm;
    logic [5:0] am;
    logic [3:0] st;
    logic       bz;
    logic [2:0] cnt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [3:0] st,
                       input logic bz, input logic [2:0] cnt);
    n_checks++;
    if (alarm_state_out === st && buzzer_en === bz && snooze_count === cnt) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got state=%b buzzer=%b count=%0d, required state=%b buzzer=%b count=%0d",
               name, alarm_state_out, buzzer_en, snooze_count, st, bz, cnt);
    end
  endtask

  // One clock edge; inputs change 1 time unit after the edge, outputs are
  // checked at the same point.
  task automatic cycle();
    @(posedge GCLK);
    #1;
    snooze_pulse  = 1'b0;
    dismiss_pulse = 1'b0;
    sec_tick      = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      cycle();
      cycle();
    end
  endtask

  initial begin
    // en sn dis cm am -> state bz cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'd29, 6'd30, S_IDLE,   1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 6'd30, 6'd30, S_ACTIVE, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 6'd30, 6'd30, S_IDLE,   1'b0, 3'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 6'd30, 6'd30, S_IDLE,   1'b0, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 6'd31, 6'd30, S_IDLE,   1'b0, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 6'd31, 6'd31, S_ACTIVE, 1'b0, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 6'd31, 6'd31, S_IDLE,   1'b0, 3'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 6'd32, 6'd30, S_IDLE,   1'b0, 3'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 6'd30, 6'd30, S_ACTIVE, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 6'd30, 6'd30, S_SNOOZE, 1'b0, 3'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 6'd30, 6'd30, S_SNOOZE, 1'b0, 3'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 6'd30, 6'd30, S_IDLE,   1'b0, 3'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 6'd30, 6'd30, S_IDLE,   1'b0, 3'd0};

    // Reset state
    #12;
    check("reset", S_IDLE, 1'b0, 3'd0);
    RST = 1'b0;

    // Single-cycle vectors: trigger, dismiss/snooze priority, re-arm, enable
    for (int i = 0; i < 13; i++) begin
      alarm_enable  = vecs[i].en;
      snooze_pulse  = vecs[i].sn;
      dismiss_pulse = vecs[i].dis;
      cur_min       = vecs[i].cm;
      alarm_min     = vecs[i].am;
      cycle();
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].bz, vecs[i].cnt);
    end

    // Fade: WAKE exactly on the 30th tick
    cur_min = 6'd29;
    cycle();
    cur_min = 6'd30;
    cycle();
    check("enter_active", S_ACTIVE, 1'b0, 3'd0);
    ticks(29);
    check("fade_29", S_ACTIVE, 1'b0, 3'd0);
    ticks(1);
    check("fade_30", S_WAKE, 1'b1, 3'd0);

    // Snooze with a coincident tick: that tick is not counted
    snooze_pulse = 1'b1;
    sec_tick     = 1'b1;
    cycle();
    check("snooze1", S_SNOOZE, 1'b0, 3'd1);
    ticks(299);
    check("snooze1_299", S_SNOOZE, 1'b0, 3'd1);
    ticks(1);
    check("snooze1_300", S_WAKE, 1'b1, 3'd1);

    snooze_pulse = 1'b1;
    cycle();
    check("snooze2", S_SNOOZE, 1'b0, 3'd2);
    ticks(300);
    check("snooze2_300", S_WAKE, 1'b1, 3'd2);

    snooze_pulse = 1'b1;
    cycle();
    check("snooze3", S_SNOOZE, 1'b0, 3'd3);
    ticks(300);
    check("snooze3_300", S_WAKE, 1'b1, 3'd3);

    snooze_pulse = 1'b1;
    cycle();
    check("snooze4_ignored", S_WAKE, 1'b1, 3'd3);

    // WAKE timeout
    ticks(4);
    check("wake_4", S_WAKE, 1'b1, 3'd3);
    ticks(1);
`ifdef ALARM_AUTO_OFF_EN
    check("wake_timeout", S_IDLE, 1'b0, 3'd3);
`else
    check("wake_5", S_WAKE, 1'b1, 3'd3);
    ticks(5);
    check("wake_10", S_WAKE, 1'b1, 3'd3);
`endif
    dismiss_pulse = 1'b1;
    cycle();
    check("dismiss_wake", S_IDLE, 1'b0, 3'd3);
    cycle();
    check("no_retrigger", S_IDLE, 1'b0, 3'd3);

    // New minute, alarm moved to it
    cur_min = 6'd31;
    cycle();
    check("min31_idle", S_IDLE, 1'b0, 3'd3);
    alarm_min = 6'd31;
    cycle();
    check("alarm_moved", S_ACTIVE, 1'b0, 3'd0);
    ticks(30);
    check("wake_again", S_WAKE, 1'b1, 3'd0);

    // Asynchronous reset mid-WAKE, release with match still true
    #2;
    RST = 1'b1;
    #1;
    check("async_rst", S_IDLE, 1'b0, 3'd0);
    #2;
    RST = 1'b0;
    cycle();
    check("rst_restart", S_ACTIVE, 1'b0, 3'd0);

    // Dismiss coincident with the expiring tick: dismiss wins
    ticks(29);
    check("pre_expiry", S_ACTIVE, 1'b0, 3'd0);
    dismiss_pulse = 1'b1;
    sec_tick      = 1'b1;
    cycle();
    check("dismiss_vs_expiry", S_IDLE, 1'b0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
